// File: rtl/ef3_pkg.sv
// Shared encodings and widths for the EF3 truth-table sequencer.
package ef3_pkg;

    localparam int unsigned IDX_W  = 4;
    localparam int unsigned F_W    = 5;
    localparam int unsigned N_COMB = 16;

    typedef enum logic [1:0] {
        ModeManual   = 2'b00,
        ModeStep     = 2'b01,
        ModeAutoOnce = 2'b10,
        ModeAutoLoop = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSettle,
        StWait,
        StCapture,
        StDone
    } state_e;

endpackage

// File: rtl/ef3_tick_counter.sv
// Loadable down-counter that saturates at zero; o_terminal flags the zero count.
module ef3_tick_counter
    import ef3_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_terminal
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_terminal = (r_count == '0);

endmodule

// File: rtl/ef3_sequencer.sv
// Drives all 16 {A,B,C,D} combinations into the EF3 block and records the returned F values,
// either manually, one step at a time, or on a timed dwell (once or looping).
module ef3_sequencer
    import ef3_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES  = 50_000_000,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              CLOCK_50,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic              step,
    input  logic [IDX_W-1:0]  sw_in,
    input  logic [F_W-1:0]    f_in,
    output logic [IDX_W-1:0]  abcd,
    output logic [F_W-1:0]    f_cap,
    output logic [IDX_W-1:0]  idx,
    output logic              busy,
    output logic              done,
    output logic [N_COMB-1:0] valid_map,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [F_W-1:0]    rd_data
);

    localparam int unsigned DWELL_W  = (DWELL_CYCLES < 1) ? 1 : $clog2(DWELL_CYCLES + 1);
    localparam int unsigned SETTLE_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    // Both counters load N-1 in DRIVE so the terminal flag appears after exactly N cycles.
    localparam logic [DWELL_W-1:0] DWELL_LOAD =
        DWELL_W'((DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 32'd0);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD =
        SETTLE_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 32'd0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_COMB - 1);

    state_e              r_state;
    state_e              w_state_next;
    mode_e               r_mode;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    r_abcd;
    logic [F_W-1:0]      r_f_cap;
    logic [F_W-1:0]      r_rd_data;
    logic [N_COMB-1:0]   r_valid;
    logic                r_step_q;
    logic [F_W-1:0]      r_mem [N_COMB];

    logic w_step_rise;
    logic w_start_sweep;
    logic w_drive;
    logic w_settle_done;
    logic w_dwell_done;
    logic w_advance;

    assign w_step_rise = step & ~r_step_q;
    assign w_drive     = (r_state == StDrive);
    assign w_advance   = (r_mode == ModeStep) ? w_step_rise : w_dwell_done;

    ef3_tick_counter #(
        .WIDTH (DWELL_W)
    ) u_dwell (
        .i_clk      (CLOCK_50),
        .i_rst      (rst),
        .i_load     (w_drive),
        .i_load_val (DWELL_LOAD),
        .i_en       (1'b1),
        .o_terminal (w_dwell_done)
    );

    ef3_tick_counter #(
        .WIDTH (SETTLE_W)
    ) u_settle (
        .i_clk      (CLOCK_50),
        .i_rst      (rst),
        .i_load     (w_drive),
        .i_load_val (SETTLE_LOAD),
        .i_en       (r_state == StSettle),
        .o_terminal (w_settle_done)
    );

    always_comb begin
        w_state_next  = r_state;
        w_start_sweep = 1'b0;
        unique case (r_state)
            StIdle: begin
                if ((mode != ModeManual) && start) begin
                    w_state_next  = StDrive;
                    w_start_sweep = 1'b1;
                end
            end
            StDrive:   w_state_next = StSettle;
            StSettle:  if (w_settle_done) w_state_next = StWait;
            StWait:    if (w_advance) w_state_next = StCapture;
            StCapture: w_state_next = (r_idx == IDX_LAST) ? StDone : StDrive;
            StDone: begin
                // Live mode is honoured here: a sweep's latched mode ends at DONE.
                if (mode == ModeAutoLoop) begin
                    w_state_next  = StDrive;
                    w_start_sweep = 1'b1;
                end else if (!start) begin
                    w_state_next = StIdle;
                end
            end
            default:   w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            r_state   <= StIdle;
            r_mode    <= ModeManual;
            r_idx     <= '0;
            r_abcd    <= '0;
            r_f_cap   <= '0;
            r_valid   <= '0;
            r_step_q  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_state   <= w_state_next;
            r_step_q  <= step;
            r_rd_data <= r_mem[rd_addr];
            case (r_state)
                StIdle: begin
                    r_idx <= '0;
                    if (mode == ModeManual) begin
                        r_abcd  <= sw_in;
                        r_f_cap <= f_in;
                    end
                end
                StDrive: r_abcd <= r_idx;
                StCapture: begin
                    r_f_cap        <= f_in;
                    r_valid[r_idx] <= 1'b1;
                    if (r_idx != IDX_LAST) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
            if (w_start_sweep) begin
                r_mode  <= mode_e'(mode);
                r_idx   <= '0;
                r_valid <= '0;
            end
        end
    end

    // Table is not cleared on reset; valid_map qualifies its entries.
    always_ff @(posedge CLOCK_50) begin
        if (!rst && (r_state == StCapture)) begin
            r_mem[r_idx] <= f_in;
        end
    end

    assign abcd      = r_abcd;
    assign f_cap     = r_f_cap;
    assign idx       = r_idx;
    assign valid_map = r_valid;
    assign rd_data   = r_rd_data;
    assign busy      = (r_state != StIdle) && (r_state != StDone);
    assign done      = (r_state == StDone);

endmodule

// File: tb/tb_ef3_sequencer.sv
// Scoreboard bench for ef3_sequencer: stimulus queues expectations, a negedge monitor checks them.
module tb_ef3_sequencer;

    localparam int P_ABCD   = 0;
    localparam int P_FCAP   = 1;
    localparam int P_IDX    = 2;
    localparam int P_BUSY   = 3;
    localparam int P_DONE   = 4;
    localparam int P_VALID  = 5;
    localparam int P_RDDATA = 6;
    localparam int P_CAPQ   = 7;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    typedef struct {
        int         idx;
        logic [4:0] f;
    } cap_t;

    chk_t q_chk[$];
    cap_t q_cap[$];
    int   checks = 0;
    int   errors = 0;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic [1:0]  mode      = 2'b00;
    logic        start     = 1'b0;
    logic        step      = 1'b0;
    logic [3:0]  sw_in     = 4'h0;
    logic [3:0]  rd_addr   = 4'h0;
    logic [4:0]  f_manual  = 5'h00;
    logic        use_model = 1'b0;
    logic [4:0]  f_in;
    logic [3:0]  abcd;
    logic [4:0]  f_cap;
    logic [3:0]  idx;
    logic        busy;
    logic        done;
    logic [15:0] valid_map;
    logic [4:0]  rd_data;

    function automatic logic [4:0] ef3_model(input logic [3:0] x);
        return ~{1'b0, x};
    endfunction

    assign f_in = use_model ? ef3_model(abcd) : f_manual;

    ef3_sequencer #(
        .DWELL_CYCLES  (4),
        .SETTLE_CYCLES (2)
    ) dut (
        .CLOCK_50  (clk),
        .rst       (rst),
        .mode      (mode),
        .start     (start),
        .step      (step),
        .sw_in     (sw_in),
        .f_in      (f_in),
        .abcd      (abcd),
        .f_cap     (f_cap),
        .idx       (idx),
        .busy      (busy),
        .done      (done),
        .valid_map (valid_map),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] probe(input int sel);
        case (sel)
            P_ABCD:   return 32'(abcd);
            P_FCAP:   return 32'(f_cap);
            P_IDX:    return 32'(idx);
            P_BUSY:   return 32'(busy);
            P_DONE:   return 32'(done);
            P_VALID:  return 32'(valid_map);
            P_RDDATA: return 32'(rd_data);
            P_CAPQ:   return 32'(q_cap.size());
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_now(input string name, input int sel, input logic [31:0] val);
        q_chk.push_back('{name, sel, val});
    endtask

    task automatic push_caps(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            q_cap.push_back('{i, ef3_model(4'(i))});
        end
    endtask

    // A timed-out wait is handed to the monitor, which then reports the unmet value.
    task automatic wait_for(input int sel, input logic [31:0] val, input int budget,
                            input string name);
        int n = 0;
        while ((probe(sel) !== val) && (n < budget)) begin
            tick(1);
            n++;
        end
        if (probe(sel) !== val) begin
            expect_now(name, sel, val);
        end
    endtask

    logic [15:0] prev_valid = 16'h0000;

    always @(negedge clk) begin
        logic [15:0] new_bits;
        chk_t        c;
        cap_t        k;
        new_bits   = valid_map & ~prev_valid;
        prev_valid = valid_map;
        if (new_bits != 16'h0000) begin
            checks++;
            if (q_cap.size() == 0) begin
                errors++;
                $display("FAIL capture: unexpected new valid bits %04h with f_cap=%02h", new_bits,
                         f_cap);
            end else begin
                k = q_cap.pop_front();
                if ((new_bits !== (16'h0001 << k.idx)) || (f_cap !== k.f)) begin
                    errors++;
                    $display("FAIL capture[%0d]: got bits=%04h f_cap=%02h, expected bits=%04h f_cap=%02h",
                             k.idx, new_bits, f_cap, 16'h0001 << k.idx, k.f);
                end
            end
        end
        while (q_chk.size() > 0) begin
            c = q_chk.pop_front();
            checks++;
            if (probe(c.sel) !== c.exp) begin
                errors++;
                $display("FAIL %s: got %0h, expected %0h", c.name, probe(c.sel), c.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(3);
        expect_now("rst_abcd",    P_ABCD,   32'h0);
        expect_now("rst_f_cap",   P_FCAP,   32'h0);
        expect_now("rst_idx",     P_IDX,    32'h0);
        expect_now("rst_busy",    P_BUSY,   32'h0);
        expect_now("rst_done",    P_DONE,   32'h0);
        expect_now("rst_valid",   P_VALID,  32'h0);
        expect_now("rst_rd_data", P_RDDATA, 32'h0);
        rst = 1'b0;

        // Manual pass-through
        sw_in    = 4'b1010;
        f_manual = 5'h13;
        tick(1);
        expect_now("man_abcd_a",  P_ABCD, 32'hA);
        expect_now("man_fcap_13", P_FCAP, 32'h13);
        expect_now("man_idx",     P_IDX,  32'h0);
        sw_in    = 4'b0101;
        f_manual = 5'h0A;
        tick(1);
        expect_now("man_abcd_5",  P_ABCD, 32'h5);
        expect_now("man_fcap_0a", P_FCAP, 32'h0A);

        // Auto-once with mode switched to manual mid-sweep
        use_model = 1'b1;
        mode      = 2'b10;
        push_caps(0, 15);
        start = 1'b1;
        tick(1);
        expect_now("once_busy", P_BUSY, 32'h1);
        wait_for(P_IDX, 32'h3, 200, "once_reach_idx3");
        mode = 2'b00;
        wait_for(P_DONE, 32'h1, 400, "once_done");
        expect_now("once_done_busy",  P_BUSY,  32'h0);
        expect_now("once_done_valid", P_VALID, 32'hFFFF);
        expect_now("once_done_abcd",  P_ABCD,  32'hF);
        sw_in = 4'b0110;
        tick(3);
        expect_now("done_hold_done", P_DONE, 32'h1);
        expect_now("done_hold_abcd", P_ABCD, 32'hF);
        start = 1'b0;
        tick(2);
        expect_now("idle_man_abcd", P_ABCD, 32'h6);
        expect_now("idle_man_done", P_DONE, 32'h0);
        expect_now("idle_man_idx",  P_IDX,  32'h0);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            tick(1);
            expect_now($sformatf("rd_data[%0d]", i), P_RDDATA, 32'(ef3_model(4'(i))));
        end

        // Reset mid-sweep at idx 7, then a clean restart
        mode = 2'b10;
        push_caps(0, 6);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_for(P_IDX, 32'h7, 200, "abort_reach_idx7");
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        expect_now("abort_idx",   P_IDX,   32'h0);
        expect_now("abort_busy",  P_BUSY,  32'h0);
        expect_now("abort_valid", P_VALID, 32'h0);
        tick(20);
        expect_now("abort_quiet_valid", P_VALID, 32'h0);
        push_caps(0, 15);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_for(P_DONE, 32'h1, 400, "restart_done");
        expect_now("restart_valid", P_VALID, 32'hFFFF);
        tick(2);

        // Step mode: held step gives one advance, a step pulse during SETTLE is dropped
        mode = 2'b01;
        push_caps(0, 0);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(8);
        step = 1'b1;
        tick(10);
        step = 1'b0;
        tick(2);
        expect_now("step_hold_idx",   P_IDX,   32'h1);
        expect_now("step_hold_valid", P_VALID, 32'h0001);
        push_caps(1, 1);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(2);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        tick(10);
        expect_now("step_settle_idx",   P_IDX,   32'h2);
        expect_now("step_settle_valid", P_VALID, 32'h0003);
        expect_now("step_settle_busy",  P_BUSY,  32'h1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;

        // Auto-loop restarts on its own after the last capture
        mode = 2'b11;
        push_caps(0, 15);
        push_caps(0, 2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_for(P_DONE, 32'h1, 400, "loop_done");
        tick(1);
        expect_now("loop_valid_clr", P_VALID, 32'h0);
        expect_now("loop_idx_zero",  P_IDX,   32'h0);
        expect_now("loop_busy",      P_BUSY,  32'h1);
        wait_for(P_VALID, 32'h0007, 100, "loop_second_pass");
        rst = 1'b1;
        tick(1);
        rst  = 1'b0;
        mode = 2'b00;
        tick(3);

        expect_now("capture_queue_empty", P_CAPQ, 32'h0);
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ef3_sequencer.md
EF3_SEQUENCER -- requirements
Module: ef3_sequencer

Interface
REQ-001 The block SHALL have exactly one clock, CLOCK_50, and one reset, rst, which SHALL be synchronous and active-high.
REQ-002 Parameter DWELL_CYCLES, default 50_000_000: hold time per input combination in auto modes (1 s at 50 MHz).
REQ-003 Parameter SETTLE_CYCLES, default 2: minimum cycles between driving abcd and capturing f_in.
REQ-004 The block SHALL have the following ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- rst  in  1  synchronous active-high reset.
- mode  in  2  operating mode: 00 manual, 01 step, 10 auto-once, 11 auto-loop.
- start  in  1  level; starts a sweep when sampled high in IDLE.
- step  in  1  debounced level; a rising edge advances the sweep in step mode.
- sw_in  in  4  manual input value, {A,B,C,D}.
- f_in  in  5  F output returned from the EF3 function block.
- abcd  out  4  drive to the EF3 function block, {A,B,C,D}.
- f_cap  out  5  last captured F.
- idx  out  4  current combination index.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high in the DONE state.
- valid_map  out  16  bit i set when F for combination i has been captured.
- rd_addr  in  4  read address into the capture table.
- rd_data  out  5  captured F at rd_addr.

Function
REQ-005 FSM states SHALL be IDLE, DRIVE, SETTLE, WAIT, CAPTURE and DONE.
REQ-006 In IDLE with mode=00, the block SHALL register abcd<=sw_in and f_cap<=f_in every cycle; idx SHALL hold 0, and the capture table SHALL be untouched.
REQ-007 In IDLE with mode!=00 and start=1, the block SHALL clear valid_map, set idx=0 and move to DRIVE; busy SHALL go high on the following cycle.
REQ-008 DRIVE SHALL set abcd<=idx for one cycle, then move to SETTLE.
REQ-009 SETTLE SHALL count SETTLE_CYCLES cycles, then move to WAIT.
REQ-010 In WAIT, mode 01 SHALL wait for a step rising edge (previous sample 0, current sample 1); modes 1x SHALL wait until DWELL_CYCLES have elapsed since DRIVE. The block SHALL then move to CAPTURE.
REQ-011 CAPTURE SHALL write mem[idx]<=f_in, f_cap<=f_in and valid_map[idx]<=1.
REQ-012 After CAPTURE, if idx==15 the block SHALL move to DONE; otherwise it SHALL set idx<=idx+1 and return to DRIVE. idx SHALL never wrap inside a sweep.
REQ-013 DONE: done=1, busy=0, and abcd SHALL hold 15.
- mode=11: the block SHALL return to IDLE-start behaviour next cycle (clear valid_map, idx=0, DRIVE) without needing start.
- Other modes: the block SHALL remain in DONE until start=0, then go to IDLE.
REQ-014 mode SHALL be latched on leaving IDLE; changes to mode during a sweep SHALL be ignored until IDLE or DONE.
REQ-015 A step edge that occurs outside WAIT SHALL be discarded. Edge detection SHALL run continuously so that a held-high step yields exactly one advance.
REQ-016 rd_data SHALL be registered with 1-cycle latency from rd_addr. Reads of entries with a clear valid_map bit SHALL return stale or zero data; callers SHALL qualify reads with valid_map.
REQ-017 The dwell counter SHALL be wide enough for DWELL_CYCLES (≥26 bits at the default), SHALL saturate rather than wrap, and SHALL reload in DRIVE.

Reset
REQ-018 When rst=1, the block SHALL go to IDLE on the next edge with abcd=0, f_cap=0, idx=0, busy=0, done=0, valid_map=0, rd_data=0, counters=0 and the step edge history=0.
REQ-019 The capture table contents need not be cleared on reset; valid_map alone qualifies them.
REQ-020 Reset asserted mid-sweep SHALL abort the sweep with no further table writes; the next sweep SHALL start at idx 0.

Structure
REQ-021 A shared package SHALL hold the mode encodings, the FSM state enumeration, and the width constants (IDX_W=4, F_W=5, N_COMB=16).
REQ-022 Exactly one sub-module, ef3_tick_counter, SHALL implement the loadable saturating dwell/settle counter with a terminal flag. The FSM, edge detector and 16x5 table SHALL stay in ef3_sequencer.

Verification
REQ-023 Reset: assert rst mid-sweep at idx=7 -> next cycle idx=0, busy=0, valid_map=0; sweep restarts from 0 after start.
REQ-024 Manual: mode=00, sw_in=4'b1010 -> abcd=4'b1010 one cycle later; f_in=5'h13 -> f_cap=5'h13 one cycle later.
REQ-025 Auto-once: DWELL_CYCLES=4, SETTLE_CYCLES=2, f_in=~abcd model -> done after 16 captures, valid_map=16'hFFFF, rd_addr=5 -> rd_data=f(5) one cycle later.
REQ-026 Step: mode=01, hold step high for 10 cycles -> exactly one idx increment; pulse step during SETTLE -> ignored.
REQ-027 Auto-loop: mode=11 -> after idx 15 capture, valid_map returns to 0 and idx=0 within 2 cycles, without start.
REQ-028 Mode change mid-sweep: switch 10->00 at idx=3 -> sweep completes to DONE; manual behaviour resumes only after IDLE.
